// File: rtl/link_monitor.sv
// link_monitor: gates the descrambler on signal detect and decides link-up.
// A link is declared up only after descrambler lock has been held for a full
// stabilize interval; fail_count records every loss of an established link.
module link_monitor #(
    parameter logic [15:0] STABILIZE_CYCLES      = 16'd41250,
    parameter logic [15:0] TEST_STABILIZE_CYCLES = 16'd625,
    parameter logic [15:0] LOCK_TIMEOUT_CYCLES   = 16'd12500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_status,
    input  logic       locked,
    input  logic       test_mode,
    output logic       descramble_enable,
    output logic       link_status,
    output logic [2:0] state,
    output logic [7:0] fail_count
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned FAIL_W  = 8;

    localparam logic [STATE_W-1:0] ST_DOWN       = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RETRY      = 3'd2;
    localparam logic [STATE_W-1:0] ST_HYSTERESIS = 3'd3;
    localparam logic [STATE_W-1:0] ST_UP         = 3'd4;

    // Timer reload values; a zero-length parameter behaves as one cycle.
    localparam logic [TIMER_W-1:0] LOCK_LOAD =
        (LOCK_TIMEOUT_CYCLES == 16'd0) ? 16'd0 : LOCK_TIMEOUT_CYCLES - 16'd1;
    localparam logic [TIMER_W-1:0] STAB_LOAD =
        (STABILIZE_CYCLES == 16'd0) ? 16'd0 : STABILIZE_CYCLES - 16'd1;
    localparam logic [TIMER_W-1:0] TEST_STAB_LOAD =
        (TEST_STABILIZE_CYCLES == 16'd0) ? 16'd0 : TEST_STABILIZE_CYCLES - 16'd1;

    localparam logic [FAIL_W-1:0] FAIL_MAX = 8'd255;

    logic [STATE_W-1:0] state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic               de_q, de_d;
    logic               link_q, link_d;

    // State, timer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DOWN;
            timer_q <= '0;
            fail_q  <= '0;
            de_q    <= 1'b0;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            de_q    <= de_d;
            link_q  <= link_d;
        end
    end

    // Next-state, timer and next-output decode; outputs follow the next state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;

        if (!signal_status) begin
            state_d = ST_DOWN;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = LOCK_LOAD;
                end
                ST_WAIT_LOCK: begin
                    if (locked) begin
                        state_d = ST_HYSTERESIS;
                        timer_d = test_mode ? TEST_STAB_LOAD : STAB_LOAD;
                    end else if (timer_q == '0) begin
                        state_d = ST_RETRY;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_RETRY: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = LOCK_LOAD;
                end
                ST_HYSTERESIS: begin
                    if (!locked) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = LOCK_LOAD;
                    end else if (timer_q == '0) begin
                        state_d = ST_UP;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_UP: begin
                    if (!locked) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = LOCK_LOAD;
                    end
                end
                default: begin
                    state_d = ST_DOWN;
                    timer_d = '0;
                end
            endcase
        end

        // Count every departure from UP, saturating.
        if ((state_q == ST_UP) && (state_d != ST_UP) && (fail_q != FAIL_MAX)) begin
            fail_d = fail_q + FAIL_W'(1);
        end

        de_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_HYSTERESIS) ||
                 (state_d == ST_UP);
        link_d = (state_d == ST_UP);
    end

    assign state             = state_q;
    assign descramble_enable = de_q;
    assign link_status       = link_q;
    assign fail_count        = fail_q;

endmodule

// File: doc/link_monitor.md
LINK_MONITOR -- requirements
Module: link_monitor

Interface
REQ-001 SHALL have parameter STABILIZE_CYCLES, default 16'd41250, hysteresis length in cycles (330 us at 125 MHz).
REQ-002 SHALL have parameter TEST_STABILIZE_CYCLES, default 16'd625, hysteresis length when test_mode=1.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 16'd12500, maximum wait for descrambler lock.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port signal_status, input, 1, PMD signal detect.
REQ-007 SHALL have port locked, input, 1, descrambler lock indication.
REQ-008 SHALL have port test_mode, input, 1, selects TEST_STABILIZE_CYCLES.
REQ-009 SHALL have port descramble_enable, output, 1, drives the descrambler's signal_status input; 0 holds the descrambler in its reset state.
REQ-010 SHALL have port link_status, output, 1, link up.
REQ-011 SHALL have port state, output, 3, current FSM state encoding.
REQ-012 SHALL have port fail_count, output, 8, count of link-up to link-down transitions.

Function
REQ-013 SHALL implement states DOWN=0, WAIT_LOCK=1, RETRY=2, HYSTERESIS=3, UP=4; all outputs SHALL be registered.
REQ-014 SHALL define descramble_enable=1 in WAIT_LOCK, HYSTERESIS and UP, and 0 in DOWN and RETRY; SHALL define link_status=1 only in UP.
REQ-015 SHALL make signal_status=0 take priority in every state: next state DOWN, timer cleared.
REQ-016 DOWN: on signal_status=1 SHALL move to WAIT_LOCK and load timer with LOCK_TIMEOUT_CYCLES-1.
REQ-017 WAIT_LOCK: locked=1 SHALL move to HYSTERESIS and load timer with (test_mode ? TEST_STABILIZE_CYCLES : STABILIZE_CYCLES)-1.
REQ-018 WAIT_LOCK: locked=0 and timer=0 SHALL move to RETRY; otherwise the timer SHALL decrement by 1.
REQ-019 SHALL make locked=1 win over timer expiry when both occur in the same WAIT_LOCK cycle.
REQ-020 RETRY SHALL last exactly one cycle, then move to WAIT_LOCK with timer reloaded to LOCK_TIMEOUT_CYCLES-1.
REQ-021 HYSTERESIS: locked=0 SHALL move to WAIT_LOCK with timer reloaded to LOCK_TIMEOUT_CYCLES-1.
REQ-022 HYSTERESIS: when locked=1 and timer=0, SHALL move to UP; otherwise the timer SHALL decrement.
REQ-023 SHALL make link_status first read 1 exactly N cycles after the first cycle state=HYSTERESIS, where N is the selected stabilize length.
REQ-024 SHALL sample test_mode only on entry to HYSTERESIS; changes during HYSTERESIS SHALL not alter the running timer.
REQ-025 UP: locked=0 SHALL move to WAIT_LOCK (timer reloaded); signal_status=0 SHALL move to DOWN.
REQ-026 SHALL increment fail_count by 1 on every transition out of UP, saturating at 8'd255 with no wrap.
REQ-027 SHALL use a 16-bit timer; parameter values of 0 SHALL behave as 1 (the load value saturates at 0).

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=DOWN, timer=0, descramble_enable=0, link_status=0, fail_count=0, in any state including mid-HYSTERESIS.
REQ-029 SHALL let the first state transition after rst_n rises be evaluated on the following edge.

Verification
REQ-030 Reset then signal_status=1, locked=1 two cycles later, test_mode=1 -> state 0->1->3; link_status=1 exactly 625 cycles after state first reads 3; fail_count=0.
REQ-031 Link up (test_mode=1), then locked=0 for 1 cycle -> state=1, link_status=0, fail_count=1; relock -> full 625-cycle hysteresis before UP again.
REQ-032 signal_status=1, locked held 0, LOCK_TIMEOUT_CYCLES=16 -> state=2 for one cycle after 16 cycles in WAIT_LOCK with descramble_enable=0 that cycle; this pattern repeats.
REQ-033 locked rises on the same cycle the WAIT_LOCK timer reaches 0 -> state=3, not 2.
REQ-034 Mid-HYSTERESIS, signal_status=0 -> next state=0, descramble_enable=0; separately, rst_n=0 mid-HYSTERESIS -> all outputs at reset values next cycle.
REQ-035 Drive 300 UP->WAIT_LOCK cycles -> fail_count stops at 255 and never wraps to 0.
